// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states,
// opcodes, ALUOp codes, mux selects and the control-word payload.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_LUI  = 6'b001111;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;

  // Shared with the ALU control decoder
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b111;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b101;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;

  localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               ior_d;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               instr_done;
    logic               illegal_op;
  } ctrl_t;

  function automatic logic is_supported(input logic [OPCODE_W-1:0] op);
    return (op == OP_R)    || (op == OP_J)   || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LUI) ||
           (op == OP_LW)   || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath (slave).
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic       InstrDone;
  logic       IllegalOp;
  logic [3:0] State;
  logic       pc_load;

  // Zero only matters to the PC load enable, which the datapath consumes
  assign pc_load = PCWrite | (PCWriteCond & Zero);

  modport master (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, InstrDone,
           IllegalOp, State
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, InstrDone,
           IllegalOp, State, pc_load
  );
endinterface

// File: rtl/multicycle_output_decode.sv
// Moore output decode: state code plus opcode/MemReady qualifiers to the
// full datapath control word.
module multicycle_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0]  state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output ctrl_t               ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.illegal_op = !is_supported(opcode);
        ctrl.instr_done = !is_supported(opcode);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.ior_d      = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        if (opcode == OP_ORI)      ctrl.alu_op = ALUOP_OR;
        else if (opcode == OP_LUI) ctrl.alu_op = ALUOP_LUI;
        else                       ctrl.alu_op = ALUOP_ADD;
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register and next-state logic,
// with control outputs decoded from the current state.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;
  logic   mem_ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     if (bus.MemReady) next_state = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_R:                    next_state = S_R_EXEC;
          OP_LW, OP_SW:            next_state = S_MEM_ADDR;
          OP_BEQ:                  next_state = S_BRANCH;
          OP_J:                    next_state = S_JUMP;
          OP_ADDI, OP_ORI, OP_LUI: next_state = S_I_EXEC;
          default:                 next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  next_state = (bus.Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.MemReady) next_state = S_MEM_WB;
      S_MEM_WRITE: if (bus.MemReady) next_state = S_FETCH;
      S_R_EXEC:    next_state = S_R_WB;
      S_I_EXEC:    next_state = S_I_WB;
      default:     next_state = S_FETCH;
    endcase
  end

  // Holding reset also blocks the MemReady-gated fetch writes
  assign mem_ready_q = bus.MemReady & reset;

  multicycle_output_decode u_decode (
    .state     (state),
    .opcode    (bus.Opcode),
    .mem_ready (mem_ready_q),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.ior_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.InstrDone   = ctrl.instr_done;
  assign bus.IllegalOp   = ctrl.illegal_op;
  assign bus.State       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected state traces with
// stall insertion, checked every cycle against a table of state outputs.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int st;
    bit mr;
  } step_t;
  step_t trace[$];

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b000010, 6'b000100, 6'b001000,
                      6'b001101, 6'b001111, 6'b100011, 6'b101011};
  endfunction

  // Expected {PCWrite..IllegalOp, pc_load} for a state
  function automatic logic [19:0] expect_vec(input int st, input logic [5:0] op,
                                             input bit mr, input bit z);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, sa, done, ill;
    logic [1:0] sb, ps;
    logic [2:0] aop;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, sa, done, ill} = '0;
    sb  = 2'b00;
    ps  = 2'b00;
    aop = 3'b100;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      1:  begin sb = 2'b11; ill = !legal(op); done = !legal(op); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mwr = 1; iord = 1; done = mr; end
      6:  begin sa = 1; aop = 3'b111; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin sa = 1; aop = 3'b001; pcwc = 1; ps = 2'b01; done = 1; end
      9:  begin pcw = 1; ps = 2'b10; done = 1; end
      10: begin
        sa = 1; sb = 2'b10;
        aop = (op == 6'b001101) ? 3'b101 : (op == 6'b001111) ? 3'b011 : 3'b100;
      end
      11: begin rw = 1; done = 1; end
      default: aop = 3'b000;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, sa, sb, ps, aop,
            done, ill, pcw | (pcwc & z)};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
            bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.InstrDone, bus.IllegalOp,
            bus.pc_load};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic add_wait(input int st, input int stalls);
    for (int i = 0; i < stalls; i++) trace.push_back('{st, 1'b0});
    trace.push_back('{st, 1'b1});
  endtask

  task automatic add_step(input int st);
    trace.push_back('{st, bit'($urandom_range(0, 1))});
  endtask

  // Expected state path of one instruction; stalls repeat the waiting state
  task automatic build_trace(input logic [5:0] op, input int fs, input int ms);
    trace.delete();
    add_wait(0, fs);
    add_step(1);
    case (op)
      6'b000000: begin add_step(6); add_step(7); end
      6'b100011: begin add_step(2); add_wait(3, ms); add_step(4); end
      6'b101011: begin add_step(2); add_wait(5, ms); end
      6'b000100: add_step(8);
      6'b000010: add_step(9);
      6'b001000, 6'b001101, 6'b001111: begin add_step(10); add_step(11); end
      default: ;
    endcase
  endtask

  // Entered 1 time unit after a rising edge; leaves in the same phase
  task automatic run_instr(input string name, input logic [5:0] op,
                           input int fs, input int ms, input int max_steps);
    int n;
    bit z;
    build_trace(op, fs, ms);
    n = (max_steps < trace.size()) ? max_steps : trace.size();
    for (int i = 0; i < n; i++) begin
      z            = bit'($urandom_range(0, 1));
      bus.Opcode   = op;
      bus.MemReady = trace[i].mr;
      bus.Zero     = z;
      #1;
      check($sformatf("%s.c%0d.state", name, i), 32'(bus.State), 32'(trace[i].st));
      check($sformatf("%s.c%0d.ctrl", name, i), 32'(dut_vec()),
            32'(expect_vec(trace[i].st, op, trace[i].mr, z)));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{6'b000000, 6'b000010, 6'b000100, 6'b001000,
            6'b001101, 6'b001111, 6'b100011, 6'b101011};

    reset        = 1'b0;
    bus.MemReady = 1'b1;
    bus.Opcode   = 6'b000000;
    bus.Zero     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.state", 32'(bus.State), 32'd0);
    check("reset.ctrl", 32'(dut_vec()), 32'(expect_vec(0, 6'b000000, 1'b0, 1'b0)));
    reset = 1'b1;

    run_instr("rtype", 6'b000000, 0, 0, 99);
    run_instr("lw_stall", 6'b100011, 0, 2, 99);
    run_instr("ori", 6'b001101, 0, 0, 99);
    run_instr("lui", 6'b001111, 0, 0, 99);
    run_instr("beq", 6'b000100, 0, 0, 99);
    run_instr("j", 6'b000010, 0, 0, 99);
    run_instr("illegal", 6'b111111, 0, 0, 99);
    run_instr("sw_fstall", 6'b101011, 1, 1, 99);

    // Reset while MEM_WRITE waits on memory
    run_instr("sw_cut", 6'b101011, 0, 3, 4);
    check("sw_cut.memwrite_before", 32'(bus.MemWrite), 32'd1);
    bus.MemReady = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("sw_cut.state", 32'(bus.State), 32'd0);
    check("sw_cut.ctrl", 32'(dut_vec()), 32'(expect_vec(0, 6'b101011, 1'b0, bus.Zero)));
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 8) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (legal(op));
      end else begin
        op = ops[$urandom_range(0, 7)];
      end
      run_instr($sformatf("rnd%0d_op%02h", k, op), op,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 99);
    end
    #1;
    check("final.state", 32'(bus.State), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore state machine that sequences the shared datapath of the multi-cycle MIPS core: one ALU, one memory port, and the PC/IR/register-file write enables. The FSM walks each instruction through fetch, decode, execute, memory and writeback. In every state it drives the 3-bit ALUOp consumed by the ALU control decoder. It sits between the instruction register (opcode source) and all datapath mux selects and write enables, and stalls on a memory-ready handshake.

## Interface
Parameters: none (all encodings come from the shared package).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; forces FETCH
- Opcode  in  6  IR[31:26]; stable from DECODE until the instruction retires
- Zero  in  1  ALU zero flag (consumed via PCWriteCond in the datapath)
- MemReady  in  1  memory completes the current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- ALUOp  out  3  111 R-type/funct, 100 add, 101 or, 011 lui, 001 subtract
- InstrDone  out  1  one-cycle pulse on the last cycle of each instruction
- IllegalOp  out  1  one-cycle pulse in DECODE for an unsupported opcode
- State  out  4  current state, for debug

## Operation
- Supported opcodes: R 000000, J 000010, BEQ 000100, ADDI 001000, ORI 001101, LUI 001111, LW 100011, SW 101011.
- States and encodings:
  - FETCH 0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00. IRWrite and PCWrite are asserted only when MemReady=1. Holds while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUOp=100 (branch target into ALUOut). Next state by opcode:
    - R → R_EXEC
    - LW/SW → MEM_ADDR
    - BEQ → BRANCH
    - J → JUMP
    - ADDI/ORI/LUI → I_EXEC
    - anything else → FETCH with IllegalOp=1 and InstrDone=1
  - MEM_ADDR 2: ALUSrcA=1, ALUSrcB=10, ALUOp=100. Goes to MEM_READ (LW) or MEM_WRITE (SW).
  - MEM_READ 3: MemRead=1, IorD=1. Holds until MemReady, then MEM_WB.
  - MEM_WB 4: RegWrite=1, RegDst=0, MemtoReg=1, InstrDone=1. Goes to FETCH.
  - MEM_WRITE 5: MemWrite=1, IorD=1. Holds until MemReady. Goes to FETCH with InstrDone=1 on the MemReady cycle.
  - R_EXEC 6: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Goes to R_WB.
  - R_WB 7: RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1. Goes to FETCH.
  - BRANCH 8: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, InstrDone=1. Goes to FETCH.
  - JUMP 9: PCWrite=1, PCSource=10, InstrDone=1. Goes to FETCH.
  - I_EXEC 10: ALUSrcA=1, ALUSrcB=10. ALUOp is 100 for ADDI, 101 for ORI, 011 for LUI. Goes to I_WB.
  - I_WB 11: RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1. Goes to FETCH.
  - Encodings 12-15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- Any output not listed for a state is 0. ALUOp defaults to 100 and ALUSrcB to 00.
- MemRead and MemWrite are never asserted in the same cycle.

## Timing
- Outputs are purely decoded from State, except the MemReady gating of IRWrite/PCWrite in FETCH and the MemReady qualification of InstrDone in MEM_WRITE.
- Outputs during and immediately after reset are the FETCH values: MemRead=1, ALUSrcB=01, ALUOp=100, everything else 0, State=0.
- Zero-wait latency, in cycles from the FETCH entry to InstrDone inclusive:
  - BEQ/J: 3
  - R, I-type, SW: 4
  - LW: 5
  - Each MemReady=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- Reset asserted mid-instruction: State returns to FETCH asynchronously. No write enable remains asserted once reset is low.

## Structure
- Shared package mips_ctrl_pkg holds the state encodings, the opcode constants, and the ALUOp constants (111/100/101/011/001). The ALU control decoder uses the same ALUOp constants; it gains 001 → subtract.
- One combinational sub-module, multicycle_output_decode: (State, Opcode, MemReady) → all control outputs.
- The state register and next-state logic stay in multicycle_control.

## Test plan
- Reset low for 2 cycles, then released with MemReady=1 → State=0, MemRead=1, ALUOp=100, ALUSrcB=01, all write enables 0. IRWrite=1 on the first post-reset edge.
- Opcode 000000, MemReady=1 → states 0,1,6,7. ALUOp=111 in state 6. RegWrite=1 and RegDst=1 in state 7. InstrDone on cycle 4.
- LW with MemReady low for 2 cycles in MEM_READ → states 0,1,2,3,3,3,4. InstrDone on cycle 7. MemtoReg=1 only in state 4.
- ORI then LUI → ALUOp=101, then 011, in state 10. Each instruction takes 4 cycles.
- BEQ, then J → BRANCH asserts PCWriteCond=1, ALUOp=001, PCSource=01. JUMP asserts PCWrite=1, PCSource=10. 3 cycles each.
- Opcode 111111 → IllegalOp and InstrDone pulse in DECODE, next State=0. Reset asserted during MEM_WRITE → MemWrite drops immediately, State=0.
